instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instruction_fetch.sv | 93 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants, FSM encoding and queue-entry layout.
package fetch_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int INST_WIDTH = 32;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } fetch_state_t;

  // Queue entries are packed MSB-first as {fault, inst, pc}.
  typedef struct packed {
    logic                  fault;
    logic [INST_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Registered instruction queue; flush empties it and overrides push/pop.
module fetch_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  // Empty head reads as zero so decode never sees stale or unreset storage.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding imem request FSM feeding a decode queue.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int dataWidth = DATA_WIDTH,
  parameter int instWidth = INST_WIDTH,
  parameter int depth     = FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [dataWidth-1:0] currentPc,
  output logic                 pc_stall,
  input  logic                 flush,
  output logic                 imem_req_valid,
  output logic [dataWidth-1:0] imem_req_addr,
  input  logic                 imem_req_ready,
  input  logic                 imem_resp_valid,
  input  logic [instWidth-1:0] imem_resp_data,
  output logic                 if_valid,
  output logic [instWidth-1:0] if_inst,
  output logic [dataWidth-1:0] if_pc,
  output logic                 if_fault,
  input  logic                 id_ready
);
  localparam int EW = 1 + instWidth + dataWidth;
  localparam int CW = $clog2(depth) + 1;

  fetch_state_t         state;
  logic                 discard;
  logic [dataWidth-1:0] pending_pc;

  logic [CW-1:0] count;
  logic          full, empty;
  logic [EW-1:0] wdata, rdata;
  logic          idle_ok, aligned, accept, mis_push, resp_push, push, pop;

  // reset gates the IDLE decisions so nothing is requested while held in reset.
  assign idle_ok        = reset && (state == IDLE) && !flush && (count < CW'(depth));
  assign aligned        = (currentPc[1:0] == 2'b00);
  assign imem_req_valid = idle_ok && aligned;
  assign imem_req_addr  = imem_req_valid ? currentPc : '0;
  assign accept         = imem_req_valid && imem_req_ready;
  assign mis_push       = idle_ok && !aligned;
  assign resp_push      = (state == WAIT_RESP) && imem_resp_valid && !discard && !flush;
  assign pc_stall       = !(accept || mis_push);

  assign push  = (mis_push || resp_push) && !full;
  assign pop   = !empty && id_ready;
  assign wdata = mis_push ? {1'b1, {instWidth{1'b0}}, currentPc}
                          : {1'b0, imem_resp_data, pending_pc};

  fetch_fifo #(.WIDTH(EW), .DEPTH(depth)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign if_valid                     = !empty;
  assign {if_fault, if_inst, if_pc}   = rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      discard    <= 1'b0;
      pending_pc <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state      <= WAIT_RESP;
          pending_pc <= currentPc;
          discard    <= 1'b0;
        end
        WAIT_RESP: begin
          // A response always retires the request; a flush without one poisons it.
          if (imem_resp_valid) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
